ecc_sec_encoder: RTL and testbench

ECC_SEC_ENCODER -- requirements
Module: ecc_sec_encoder

---
 rtl/ecc_sec_encoder_if.sv | 48 ++++
 rtl/ecc_sec_encoder.sv | 106 ++++++++++
 tb/tb_ecc_sec_encoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_sec_encoder_if.sv
// Handshake bundle between the SEC encoder and its upstream source / downstream corrector.
// Gerr_inj exists only when ECC_ERRINJ_EN is defined.
interface ecc_sec_encoder_if;
    logic        Gin_valid;
    logic        Gin_ready;
    logic [31:0] Gin_data;
    logic        Gout_valid;
    logic        Gout_ready;
    logic [31:0] Gout_data;
    logic [7:0]  Gout_chk;
    logic        Gout_r;
    logic [15:0] Gword_cnt;
`ifdef ECC_ERRINJ_EN
    logic [5:0]  Gerr_inj;
`endif

    // Encoder side.
    modport master (
`ifdef ECC_ERRINJ_EN
        input  Gerr_inj,
`endif
        input  Gin_valid,
        input  Gin_data,
        input  Gout_ready,
        output Gin_ready,
        output Gout_valid,
        output Gout_data,
        output Gout_chk,
        output Gout_r,
        output Gword_cnt
    );

    // Environment side: upstream source plus downstream corrector.
    modport slave (
`ifdef ECC_ERRINJ_EN
        output Gerr_inj,
`endif
        output Gin_valid,
        output Gin_data,
        output Gout_ready,
        input  Gin_ready,
        input  Gout_valid,
        input  Gout_data,
        input  Gout_chk,
        input  Gout_r,
        input  Gword_cnt
    );
endinterface

// File: rtl/ecc_sec_encoder.sv
// 32-bit SEC check-bit encoder with a two-entry (output + skid) elastic buffer.
// Define ECC_ERRINJ_EN to build in single-bit error injection on stored data.
module ecc_sec_encoder (
    input logic               Gclk,
    input logic               Grst_n,
    ecc_sec_encoder_if.master bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    localparam logic [31:0] ChkMask [8] = '{
        32'h00FF_1111, 32'hFF00_2222, 32'h0F0F_4444, 32'hF0F0_8888,
        32'h1111_00FF, 32'h2222_FF00, 32'h4444_0F0F, 32'h8888_F0F0
    };

    state_e      r_state, w_state_d;
    logic [31:0] r_out_data, r_skid_data, w_out_data_d, w_skid_data_d, w_store_data;
    logic [7:0]  r_out_chk, r_skid_chk, w_out_chk_d, w_skid_chk_d, w_chk;
    logic        r_in_ready;
    logic [15:0] r_word_cnt;
    logic        w_out_valid, w_in_fire, w_out_fire;

    always_comb begin
        w_chk = '0;
        for (int k = 0; k < 8; k++) begin
            w_chk[k] = ^(bus.Gin_data & ChkMask[k]);
        end
    end

    // The flip is applied after encoding so the stored word carries a correctable error.
`ifdef ECC_ERRINJ_EN
    assign w_store_data = bus.Gin_data ^ ({31'b0, bus.Gerr_inj[5]} << bus.Gerr_inj[4:0]);
`else
    assign w_store_data = bus.Gin_data;
`endif

    assign w_out_valid = (r_state != StEmpty);
    assign w_in_fire   = bus.Gin_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & bus.Gout_ready;

    always_comb begin
        w_state_d     = r_state;
        w_out_data_d  = r_out_data;
        w_out_chk_d   = r_out_chk;
        w_skid_data_d = r_skid_data;
        w_skid_chk_d  = r_skid_chk;
        case (r_state)
            StEmpty: begin
                if (w_in_fire) begin
                    w_state_d    = StOne;
                    w_out_data_d = w_store_data;
                    w_out_chk_d  = w_chk;
                end
            end
            StOne: begin
                if (w_in_fire && w_out_fire) begin
                    w_out_data_d = w_store_data;
                    w_out_chk_d  = w_chk;
                end else if (w_in_fire) begin
                    w_state_d     = StFull;
                    w_skid_data_d = w_store_data;
                    w_skid_chk_d  = w_chk;
                end else if (w_out_fire) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                if (w_out_fire) begin
                    w_state_d    = StOne;
                    w_out_data_d = r_skid_data;
                    w_out_chk_d  = r_skid_chk;
                end
            end
            default: w_state_d = StEmpty;
        endcase
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_chk   <= '0;
            r_skid_data <= '0;
            r_skid_chk  <= '0;
            r_word_cnt  <= '0;
        end else begin
            r_state     <= w_state_d;
            // Registered ready keeps Gout_ready off the upstream timing path.
            r_in_ready  <= (w_state_d != StFull);
            r_out_data  <= w_out_data_d;
            r_out_chk   <= w_out_chk_d;
            r_skid_data <= w_skid_data_d;
            r_skid_chk  <= w_skid_chk_d;
            if (w_in_fire) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign bus.Gin_ready  = r_in_ready;
    assign bus.Gout_valid = w_out_valid;
    assign bus.Gout_r     = w_out_valid;
    assign bus.Gout_data  = w_out_valid ? r_out_data : '0;
    assign bus.Gout_chk   = w_out_valid ? r_out_chk : '0;
    assign bus.Gword_cnt  = r_word_cnt;
endmodule

// File: tb/tb_ecc_sec_encoder.sv
// Directed bench for ecc_sec_encoder: encoding table, backpressure, streaming, reset, wrap.
module tb_ecc_sec_encoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  chk;
    } vec_t;

    // Syndrome contributed by each single data bit, derived by hand from the group lists.
    localparam logic [7:0] Syn [32] = '{
        8'h51, 8'h52, 8'h54, 8'h58, 8'h91, 8'h92, 8'h94, 8'h98,
        8'h61, 8'h62, 8'h64, 8'h68, 8'hA1, 8'hA2, 8'hA4, 8'hA8,
        8'h15, 8'h25, 8'h45, 8'h85, 8'h19, 8'h29, 8'h49, 8'h89,
        8'h16, 8'h26, 8'h46, 8'h86, 8'h1A, 8'h2A, 8'h4A, 8'h8A
    };

    ecc_sec_encoder_if bus ();

    ecc_sec_encoder dut (
        .Gclk   (clk),
        .Grst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_chk(input logic [31:0] d);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < 32; k++) begin
            if (d[k]) s = s ^ Syn[k];
        end
        return s;
    endfunction

    function automatic logic [31:0] stream_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t        vecs [14];
    logic [15:0] exp_cnt;

    initial begin
        vecs[0]  = '{32'h0000_0000, 8'h00};
        vecs[1]  = '{32'h0000_0001, 8'h51};
        vecs[2]  = '{32'hFFFF_FFFF, 8'h00};
        vecs[3]  = '{32'h8000_0000, 8'h8A};
        vecs[4]  = '{32'h0001_0000, 8'h15};
        vecs[5]  = '{32'h0000_0100, 8'h61};
        vecs[6]  = '{32'h0000_000F, 8'h0F};
        vecs[7]  = '{32'h0000_00FF, 8'h00};
        vecs[8]  = '{32'h0000_0101, 8'h30};
        vecs[9]  = '{32'h8001_0000, 8'h9F};
        vecs[10] = '{32'h0002_0000, 8'h25};
        vecs[11] = '{32'h0000_F000, 8'h0F};
        vecs[12] = '{32'h0000_1000, 8'hA1};
        vecs[13] = '{32'hF000_0000, 8'hF0};

        bus.Gin_valid  = 1'b0;
        bus.Gin_data   = '0;
        bus.Gout_ready = 1'b0;
`ifdef ECC_ERRINJ_EN
        bus.Gerr_inj   = '0;
`endif

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", 32'(bus.Gin_ready), 32'd0);
        check("rst_out_valid", 32'(bus.Gout_valid), 32'd0);
        check("rst_out_r", 32'(bus.Gout_r), 32'd0);
        check("rst_out_data", bus.Gout_data, 32'd0);
        check("rst_out_chk", 32'(bus.Gout_chk), 32'd0);
        check("rst_cnt", 32'(bus.Gword_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.Gin_ready), 32'd1);
        check("empty_after_rst", 32'(bus.Gout_valid), 32'd0);

        // Encoding table, one word at a time.
        exp_cnt = 16'd0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.Gin_valid  = 1'b1;
            bus.Gin_data   = vecs[i].data;
            bus.Gout_ready = 1'b1;
            @(negedge clk);
            exp_cnt++;
            check("vec_valid", 32'(bus.Gout_valid), 32'd1);
            check("vec_r", 32'(bus.Gout_r), 32'd1);
            check("vec_data", bus.Gout_data, vecs[i].data);
            check("vec_chk", 32'(bus.Gout_chk), 32'(vecs[i].chk));
            bus.Gin_valid = 1'b0;
            bus.Gin_data  = '0;
            @(negedge clk);
            check("vec_idle_valid", 32'(bus.Gout_valid), 32'd0);
            check("vec_idle_data", bus.Gout_data, 32'd0);
            check("vec_idle_chk", 32'(bus.Gout_chk), 32'd0);
        end
        check("vec_cnt", 32'(bus.Gword_cnt), 32'(exp_cnt));

        // Backpressure: A and B accepted, C held, then drained in order.
        bus.Gout_ready = 1'b0;
        bus.Gin_valid  = 1'b1;
        bus.Gin_data   = 32'h0000_0001;
        @(negedge clk);
        check("bp_a_out", bus.Gout_data, 32'h0000_0001);
        check("bp_ready_one", 32'(bus.Gin_ready), 32'd1);
        bus.Gin_data = 32'h8000_0000;
        @(negedge clk);
        check("bp_ready_full", 32'(bus.Gin_ready), 32'd0);
        bus.Gin_data = 32'h0001_0000;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("bp_stall_valid", 32'(bus.Gout_valid), 32'd1);
            check("bp_stall_data", bus.Gout_data, 32'h0000_0001);
            check("bp_stall_chk", 32'(bus.Gout_chk), 32'h51);
            check("bp_stall_ready", 32'(bus.Gin_ready), 32'd0);
            check("bp_stall_cnt", 32'(bus.Gword_cnt), 32'(exp_cnt + 16'd2));
        end
        bus.Gout_ready = 1'b1;
        @(negedge clk);
        check("bp_b_data", bus.Gout_data, 32'h8000_0000);
        check("bp_b_chk", 32'(bus.Gout_chk), 32'h8A);
        check("bp_ready_back", 32'(bus.Gin_ready), 32'd1);
        @(negedge clk);
        check("bp_c_data", bus.Gout_data, 32'h0001_0000);
        check("bp_c_chk", 32'(bus.Gout_chk), 32'h15);
        check("bp_cnt", 32'(bus.Gword_cnt), 32'(exp_cnt + 16'd3));
        bus.Gin_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 32'(bus.Gout_valid), 32'd0);

        // Streaming: 100 words, one per cycle.
        do_reset();
        bus.Gout_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                check("st_valid", 32'(bus.Gout_valid), 32'd1);
                check("st_data", bus.Gout_data, stream_word(i - 1));
                check("st_chk", 32'(bus.Gout_chk), 32'(model_chk(stream_word(i - 1))));
            end
            bus.Gin_valid = 1'b1;
            bus.Gin_data  = stream_word(i);
            @(negedge clk);
        end
        check("st_last_data", bus.Gout_data, stream_word(99));
        check("st_last_chk", 32'(bus.Gout_chk), 32'(model_chk(stream_word(99))));
        check("st_cnt", 32'(bus.Gword_cnt), 32'd100);
        bus.Gin_valid = 1'b0;
        @(negedge clk);
        check("st_empty", 32'(bus.Gout_valid), 32'd0);

`ifdef ECC_ERRINJ_EN
        bus.Gin_valid = 1'b1;
        bus.Gin_data  = 32'h0000_0000;
        bus.Gerr_inj  = 6'h25;
        @(negedge clk);
        check("inj_data", bus.Gout_data, 32'h0000_0020);
        check("inj_chk", 32'(bus.Gout_chk), 32'h00);
        bus.Gin_valid = 1'b0;
        bus.Gerr_inj  = 6'h00;
        @(negedge clk);
`endif

        // Reset while FULL discards both entries at once.
        bus.Gout_ready = 1'b0;
        bus.Gin_valid  = 1'b1;
        bus.Gin_data   = 32'h1111_0000;
        @(negedge clk);
        bus.Gin_data = 32'h2222_0000;
        @(negedge clk);
        bus.Gin_valid = 1'b0;
        check("full_ready", 32'(bus.Gin_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.Gout_valid), 32'd0);
        check("arst_data", bus.Gout_data, 32'd0);
        check("arst_chk", 32'(bus.Gout_chk), 32'd0);
        check("arst_cnt", 32'(bus.Gword_cnt), 32'd0);
        check("arst_ready", 32'(bus.Gin_ready), 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.Gout_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("arst_no_stale", 32'(bus.Gout_valid), 32'd0);
        end
        check("arst_ready_up", 32'(bus.Gin_ready), 32'd1);

        // Counter wrap.
        do_reset();
        bus.Gout_ready = 1'b1;
        bus.Gin_valid  = 1'b1;
        bus.Gin_data   = 32'h0000_0000;
        repeat (65535) @(negedge clk);
        check("wrap_ffff", 32'(bus.Gword_cnt), 32'h0000_FFFF);
        @(negedge clk);
        check("wrap_zero", 32'(bus.Gword_cnt), 32'h0000_0000);
        bus.Gin_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
